// File: rtl/lcd_rom_sequencer.sv
// HD44780 power-up/init sequencer followed by on-demand replay of a small message ROM
// onto an 8-bit parallel LCD bus, with RS/E timing and per-command settle waits.
module lcd_rom_sequencer #(
  parameter int ADDR_W       = 4,
  parameter int ROM_LAST     = 15,
  parameter int POWERUP_CYC  = 750000,
  parameter int SETUP_CYC    = 2,
  parameter int E_PULSE_CYC  = 12,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e,
  output logic [7:0]        lcd_db,
  output logic              busy,
  output logic              done
);

  localparam int MAX_A   = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0]  CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [ADDR_W-1:0] ROM_LAST_A = ADDR_W'(ROM_LAST);
  localparam logic [2:0]        INIT_LAST  = 3'd4;

  typedef enum logic [1:0] {PWRUP, INIT, READY, PLAY} top_e;
  typedef enum logic [1:0] {W_LATCH, W_SETUP, W_PULSE, W_WAIT} wr_e;

  top_e              top_q, top_d;
  wr_e               wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        init_idx_q, init_idx_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rs_q, rs_d;
  logic [7:0]        db_q, db_d;
  logic              e_q, e_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_prev_q;
  logic [8:0]        word_s;
  logic [CNT_W-1:0]  wait_last_s;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h38;
      3'd2:    init_byte = 8'h0C;
      3'd3:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // Clear and home commands need the long settle time
  assign wait_last_s = (!rs_q && (db_q == 8'h01 || db_q == 8'h02)) ? CLR_LAST : CMD_LAST;
  assign word_s      = (top_q == INIT) ? {1'b0, init_byte(init_idx_q)} : rom_data;

  always_comb begin
    top_d      = top_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    init_idx_d = init_idx_q;
    rom_addr_d = rom_addr_q;
    rs_d       = rs_q;
    db_d       = db_q;
    e_d        = 1'b0;
    done_d     = 1'b0;
    case (top_q)
      PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          top_d      = INIT;
          wr_d       = W_LATCH;
          cnt_d      = '0;
          init_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READY: begin
        // Rising edge only, so a held start cannot trigger a second replay
        if (start && !start_prev_q) begin
          top_d      = PLAY;
          wr_d       = W_LATCH;
          cnt_d      = '0;
          rom_addr_d = '0;
        end else begin
          top_d = READY;
        end
      end
      INIT, PLAY: begin
        case (wr_q)
          W_LATCH: begin
            rs_d  = word_s[8];
            db_d  = word_s[7:0];
            wr_d  = W_SETUP;
            cnt_d = '0;
          end
          W_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
              wr_d  = W_PULSE;
              cnt_d = '0;
              e_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          W_PULSE: begin
            if (cnt_q == PULSE_LAST) begin
              wr_d  = W_WAIT;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              e_d   = 1'b1;
            end
          end
          W_WAIT: begin
            if (cnt_q == wait_last_s) begin
              cnt_d = '0;
              wr_d  = W_LATCH;
              if (top_q == INIT) begin
                if (init_idx_q == INIT_LAST) begin
                  top_d = READY;
                end else begin
                  init_idx_d = init_idx_q + 3'd1;
                end
              end else if (rom_addr_q == ROM_LAST_A) begin
                top_d      = READY;
                done_d     = 1'b1;
                rom_addr_d = '0;
              end else begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            wr_d  = W_LATCH;
            cnt_d = '0;
          end
        endcase
      end
      default: begin
        top_d = PWRUP;
        cnt_d = '0;
      end
    endcase
    busy_d = (top_d != READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q        <= PWRUP;
      wr_q         <= W_LATCH;
      cnt_q        <= '0;
      init_idx_q   <= 3'd0;
      rom_addr_q   <= '0;
      rs_q         <= 1'b0;
      db_q         <= 8'h00;
      e_q          <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      top_q        <= top_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      init_idx_q   <= init_idx_d;
      rom_addr_q   <= rom_addr_d;
      rs_q         <= rs_d;
      db_q         <= db_d;
      e_q          <= e_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_prev_q <= start;
    end
  end

  assign rom_addr = rom_addr_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_db   = db_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lcd_rom_sequencer.sv
// Randomized bench for lcd_rom_sequencer: an event-schedule model predicts every E pulse,
// the busy window and done pulses from the command timing rules.
module tb_lcd_rom_sequencer;
  localparam int ADDR_W   = 4;
  localparam int ROM_LAST = 3;
  localparam int POWERUP  = 20;
  localparam int SETUP    = 1;
  localparam int PULSE    = 2;
  localparam int CMD_WAIT = 4;
  localparam int CLR_WAIT = 10;

  typedef struct {
    int         rise;
    logic       rs;
    logic [7:0] db;
  } pulse_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0]        rom_data;
  logic              lcd_rs, lcd_rw, lcd_e, busy, done;
  logic [7:0]        lcd_db;
  logic [8:0]        rom_mem [16];

  pulse_t     pq[$];
  int         dq[$];
  int         cyc, ready_from, n_cmp, n_err;
  logic       prev_e, first_play;
  logic [8:0] prev_rsdb;

  lcd_rom_sequencer #(
    .ADDR_W(ADDR_W), .ROM_LAST(ROM_LAST), .POWERUP_CYC(POWERUP), .SETUP_CYC(SETUP),
    .E_PULSE_CYC(PULSE), .CMD_WAIT_CYC(CMD_WAIT), .CLR_WAIT_CYC(CLR_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db), .busy(busy), .done(done)
  );

  assign rom_data = rom_mem[rom_addr];

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // One write occupies latch + setup + pulse + settle; E is visible high from latch+1+SETUP
  task automatic sched_word(inout int t, input logic rs, input logic [7:0] db);
    pulse_t p;
    p.rise = t + 1 + SETUP;
    p.rs   = rs;
    p.db   = db;
    pq.push_back(p);
    t = t + 1 + SETUP + PULSE + ((!rs && (db == 8'h01 || db == 8'h02)) ? CLR_WAIT : CMD_WAIT);
  endtask

  task automatic sched_init(input int r);
    logic [7:0] ib [5];
    int t;
    ib = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    pq.delete();
    dq.delete();
    t = r + POWERUP;
    for (int i = 0; i < 5; i++) sched_word(t, 1'b0, ib[i]);
    ready_from = t;
  endtask

  task automatic sched_play(input int n);
    int t;
    t = n + 1;
    for (int i = 0; i <= ROM_LAST; i++) sched_word(t, rom_mem[i][8], rom_mem[i][7:0]);
    dq.push_back(t);
    ready_from = t;
  endtask

  task automatic load_rom();
    int sel;
    if (first_play) begin
      rom_mem[0] = 9'h080;
      rom_mem[1] = 9'h148;
      rom_mem[2] = 9'h165;
      rom_mem[3] = 9'h101;
      first_play = 1'b0;
    end else begin
      for (int i = 0; i <= ROM_LAST; i++) begin
        sel = $urandom_range(0, 3);
        rom_mem[i][8]   = 1'($urandom_range(0, 1));
        rom_mem[i][7:0] = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_val("rst_e", 32'(lcd_e), 32'd0);
    check_val("rst_rs", 32'(lcd_rs), 32'd0);
    check_val("rst_db", 32'(lcd_db), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd1);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_rw", 32'(lcd_rw), 32'd0);
  endtask

  task automatic check_cycle();
    logic exp_e, exp_done, exp_busy;
    while (pq.size() > 0 && cyc >= pq[0].rise + PULSE) void'(pq.pop_front());
    exp_e = (pq.size() > 0) && (cyc >= pq[0].rise);
    check_val("lcd_e", 32'(lcd_e), 32'(exp_e));
    if (exp_e) begin
      check_val("lcd_rs", 32'(lcd_rs), 32'(pq[0].rs));
      check_val("lcd_db", 32'(lcd_db), 32'(pq[0].db));
    end
    if (lcd_e) check_val("rsdb_stable", 32'({lcd_rs, lcd_db}), 32'(prev_rsdb));
    check_val("lcd_rw", 32'(lcd_rw), 32'd0);
    exp_busy = (cyc < ready_from);
    check_val("busy", 32'(busy), 32'(exp_busy));
    if (!exp_busy) check_val("rom_addr_idle", 32'(rom_addr), 32'd0);
    exp_done = 1'b0;
    while (dq.size() > 0 && dq[0] < cyc) void'(dq.pop_front());
    if (dq.size() > 0 && dq[0] == cyc) begin
      exp_done = 1'b1;
      void'(dq.pop_front());
    end
    check_val("done", 32'(done), 32'(exp_done));
    prev_e    = lcd_e;
    prev_rsdb = {lcd_rs, lcd_db};
  endtask

  task automatic drive_start();
    logic ns;
    if (start) ns = ($urandom_range(0, 3) != 0);
    else       ns = ($urandom_range(0, 19) == 0);
    if (ns && !start && cyc >= ready_from) begin
      load_rom();
      sched_play(cyc);
    end
    start = ns;
  endtask

  task automatic release_reset();
    reset     = 1'b0;
    start     = 1'b0;
    prev_e    = 1'b0;
    prev_rsdb = 9'h000;
    sched_init(cyc);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int guard;
    reset      = 1'b1;
    start      = 1'b0;
    n_cmp      = 0;
    n_err      = 0;
    cyc        = 0;
    ready_from = 0;
    first_play = 1'b1;
    prev_e     = 1'b0;
    prev_rsdb  = 9'h000;
    for (int i = 0; i < 16; i++) rom_mem[i] = 9'h000;

    repeat (2) next_cycle();
    check_reset_state();
    release_reset();

    for (int k = 0; k < 1500; k++) begin
      next_cycle();
      check_cycle();
      drive_start();
    end

    // Hit an active E strobe with reset: it must drop without waiting for a clock
    guard = 0;
    while (!lcd_e && guard < 400) begin
      next_cycle();
      check_cycle();
      drive_start();
      guard++;
    end
    check_val("e_high_before_reset", 32'(lcd_e), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("async_e_drop", 32'(lcd_e), 32'd0);
    check_val("async_busy", 32'(busy), 32'd1);
    check_val("async_done", 32'(done), 32'd0);
    start = 1'b0;
    next_cycle();
    check_reset_state();
    release_reset();

    for (int k = 0; k < 400; k++) begin
      next_cycle();
      check_cycle();
      drive_start();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
